seg7_mux_capture: RTL and testbench
===================================

Name: seg7_mux_capture

Overview:
Receive-side counterpart of the two-digit multiplexed seven-segment driver. It samples segment and digit-enable lines and removes the polarity inversion. It debounces each digit's pattern across multiplex slots and decodes it back to BCD. It sits on the bench/host side (or on a second die input bank) to read back what the dice display shows, with stale-digit timeout and error reporting.

Parameters:
STABLE_CNT, 4, consecutive identical samples of a digit required before commit (>=1)
TIMEOUT, 1024, cycles without any sample of a digit before that digit is marked blank (>=2)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
seg_in  in  8  segment lines, bit0=a … bit6=g, bit7=dp (ignored)
dig_en  in  2  digit enables, bit0=ones digit, bit1=tens digit
seg_inv  in  1  1: segment lines active-low (common anode); quasi-static
dig_inv  in  1  1: digit enables active-low; quasi-static
err_clr  in  1  synchronous clear of seg_err
digit1  out  4  decoded ones digit
digit10  out  4  decoded tens digit
d1_valid  out  1  ones digit lit and decoded
d10_valid  out  1  tens digit lit and decoded
seg_err  out  1  sticky: invalid pattern or enable conflict seen
update  out  1  one-cycle pulse after any change of {digit10,d10_valid,digit1,d1_valid}

Behaviour:
- Reset (async, rst_n=0): all outputs 0; all internal counters, pattern registers and synchronizers 0.
- Input path: seg_in[6:0] and dig_en pass through 2-FF synchronizers. Apply the inversions after sync: seg = seg_inv ? ~s : s; en = dig_inv ? ~e : e.
- Sample classification, each cycle:
  - en=01 → sample for ones digit.
  - en=10 → sample for tens digit.
  - en=00 → idle, no sample.
  - en=11 → conflict: discard sample, set seg_err.
- Per-digit stability tracker (pattern reg 7b, run counter saturating at STABLE_CNT):
  - Sample equal to pattern reg → counter++ (saturating).
  - Sample different → pattern reg <= sample, counter <= 1.
  - Commit when counter_next == STABLE_CNT and counter != STABLE_CNT, i.e. once per stable run.
- Commit decode, canonical patterns only: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F.
  - 00 (blank) → digit <= 0, valid <= 0.
  - Decodable pattern → digit <= code, valid <= 1.
  - Any other pattern → seg_err <= 1; digit and valid unchanged.
- Latency: an input pattern held steady with its enable active changes outputs on rising edge STABLE_CNT+2 after first presence (2 sync + STABLE_CNT samples). update is high for the cycle following that edge, and only if the value actually changed.
- Timeout: each digit has an age counter. It clears to 0 on every sample of that digit, otherwise increments, saturating at TIMEOUT.
  - Reaching TIMEOUT → digit <= 0, valid <= 0, run counter <= 0. update pulses if the value changed.
  - This means the blanked tens digit (driver suppresses leading zero, enable never asserted) reads as d10_valid=0 after TIMEOUT.
- Both digits may commit on the same edge only via timeout; update is still a single one-cycle pulse.
- err_clr clears seg_err. If a new error occurs in the same cycle, set wins.
- Multiplex slots with STABLE_CNT > slot length still work, because samples accumulate across slots (idle cycles do not reset the run counter).
- Changing seg_inv/dig_inv mid-operation is allowed. Resulting glitch samples must not commit unless they are stable for STABLE_CNT samples.

Optional Feature:
SEG7_HEX_DECODE_EN. Defined: additionally decode A=77 b=7C C=39 d=5E E=79 F=71 to codes 10–15 with valid=1. Undefined: these patterns are invalid and set seg_err.

Test Plan:
- seg_inv=0,dig_inv=0, dig_en=01, seg_in=5B held → digit1=2,d1_valid=1 at edge 6; update high one cycle; seg_err=0.
- Alternate dig_en 01/10 every cycle, ones=66, tens=06, seg_inv=1,dig_inv=1 with lines inverted → digit1=4, digit10=1, both valid.
- Ones pattern toggling 06/5B every 3 cycles (STABLE_CNT=4) → no commit, digits stay 0, update never pulses.
- dig_en=11 for one cycle → seg_err=1. err_clr pulse → 0. err_clr coincident with seg_in=7E commit → seg_err stays 1.
- Display 20 then tens enable stops → after TIMEOUT(1024) idle cycles d10_valid=0, digit10=0, single update pulse; digit1 unaffected while still sampled.
- Assert rst_n low mid-stable-run (counter=3) → outputs 0 immediately. After release, the full STABLE_CNT+2 latency is needed again.

Source files
------------

// File: rtl/seg7_mux_capture.sv
// Read-back of a two-digit multiplexed seven-segment display: sync, polarity fix, debounce, decode to BCD.
// Define SEG7_HEX_DECODE_EN to also accept the A-F hex glyphs as codes 10-15.
module seg7_mux_capture #(
  parameter int STABLE_CNT = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] seg_in_i,
  input  logic [1:0] dig_en_i,
  input  logic       seg_inv_i,
  input  logic       dig_inv_i,
  input  logic       err_clr_i,
  output logic [3:0] digit1_o,
  output logic [3:0] digit10_o,
  output logic       d1_valid_o,
  output logic       d10_valid_o,
  output logic       seg_err_o,
  output logic       update_o
);

  localparam int RUN_W = $clog2(STABLE_CNT + 1);
  localparam int AGE_W = $clog2(TIMEOUT + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CNT);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(TIMEOUT);

  // Returns {pattern_ok, lit, code}; blank is ok but not lit.
  function automatic logic [5:0] dec7(input logic [6:0] p);
    logic [5:0] r;
    r = 6'b0;
    case (p)
      7'h00: r = {2'b10, 4'd0};
      7'h3F: r = {2'b11, 4'd0};
      7'h06: r = {2'b11, 4'd1};
      7'h5B: r = {2'b11, 4'd2};
      7'h4F: r = {2'b11, 4'd3};
      7'h66: r = {2'b11, 4'd4};
      7'h6D: r = {2'b11, 4'd5};
      7'h7D: r = {2'b11, 4'd6};
      7'h07: r = {2'b11, 4'd7};
      7'h7F: r = {2'b11, 4'd8};
      7'h6F: r = {2'b11, 4'd9};
`ifdef SEG7_HEX_DECODE_EN
      7'h77: r = {2'b11, 4'd10};
      7'h7C: r = {2'b11, 4'd11};
      7'h39: r = {2'b11, 4'd12};
      7'h5E: r = {2'b11, 4'd13};
      7'h79: r = {2'b11, 4'd14};
      7'h71: r = {2'b11, 4'd15};
`endif
      default: r = 6'b0;
    endcase
    return r;
  endfunction

  logic       unused_dp;
  logic [6:0] seg_s1_q, seg_s2_q;
  logic [1:0] en_s1_q, en_s2_q;
  logic [6:0] seg;
  logic [1:0] en;
  logic [1:0] smp;

  // Index 0 is the ones digit, index 1 the tens digit.
  logic [1:0][6:0]       pat_q, pat_d;
  logic [1:0][RUN_W-1:0] run_q, run_d;
  logic [1:0][AGE_W-1:0] age_q, age_d;
  logic [1:0][3:0]       dig_q, dig_d;
  logic [1:0]            val_q, val_d;
  logic                  err_q, err_d;
  logic                  upd_q, upd_d;
  logic                  err_set;
  logic [5:0]            dec_c;
  logic                  commit_c;

  assign unused_dp = seg_in_i[7];
  assign seg = seg_inv_i ? ~seg_s2_q : seg_s2_q;
  assign en  = dig_inv_i ? ~en_s2_q : en_s2_q;
  assign smp = {en == 2'b10, en == 2'b01};

  always_comb begin
    pat_d    = pat_q;
    run_d    = run_q;
    age_d    = age_q;
    dig_d    = dig_q;
    val_d    = val_q;
    dec_c    = 6'b0;
    commit_c = 1'b0;
    err_set  = (en == 2'b11);
    for (int i = 0; i < 2; i++) begin
      if (smp[i]) begin
        age_d[i] = '0;
        if (seg == pat_q[i]) begin
          if (run_q[i] != RUN_MAX) run_d[i] = run_q[i] + 1'b1;
          commit_c = (run_d[i] == RUN_MAX) && (run_q[i] != RUN_MAX);
        end else begin
          pat_d[i] = seg;
          run_d[i] = RUN_W'(1);
          commit_c = (run_d[i] == RUN_MAX);
        end
        if (commit_c) begin
          dec_c = dec7(seg);
          if (!dec_c[5]) begin
            err_set = 1'b1;
          end else begin
            dig_d[i] = dec_c[3:0];
            val_d[i] = dec_c[4];
          end
        end
      end else if (age_q[i] != AGE_MAX) begin
        age_d[i] = age_q[i] + 1'b1;
        if (age_d[i] == AGE_MAX) begin
          dig_d[i] = 4'd0;
          val_d[i] = 1'b0;
          run_d[i] = '0;
        end
      end
    end
    err_d = (err_q & ~err_clr_i) | err_set;
    upd_d = ({dig_d, val_d} != {dig_q, val_q});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1_q <= '0;
      seg_s2_q <= '0;
      en_s1_q  <= '0;
      en_s2_q  <= '0;
      pat_q    <= '0;
      run_q    <= '0;
      age_q    <= '0;
      dig_q    <= '0;
      val_q    <= '0;
      err_q    <= 1'b0;
      upd_q    <= 1'b0;
    end else begin
      seg_s1_q <= seg_in_i[6:0];
      seg_s2_q <= seg_s1_q;
      en_s1_q  <= dig_en_i;
      en_s2_q  <= en_s1_q;
      pat_q    <= pat_d;
      run_q    <= run_d;
      age_q    <= age_d;
      dig_q    <= dig_d;
      val_q    <= val_d;
      err_q    <= err_d;
      upd_q    <= upd_d;
    end
  end

  assign digit1_o    = dig_q[0];
  assign digit10_o   = dig_q[1];
  assign d1_valid_o  = val_q[0];
  assign d10_valid_o = val_q[1];
  assign seg_err_o   = err_q;
  assign update_o    = upd_q;

endmodule

// File: tb/tb_seg7_mux_capture.sv
// Directed bench for seg7_mux_capture: decode table plus latency, debounce, error and timeout sequences.
module tb_seg7_mux_capture;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] seg_in_i = 8'h00;
  logic [1:0] dig_en_i = 2'b00;
  logic       seg_inv_i = 1'b0;
  logic       dig_inv_i = 1'b0;
  logic       err_clr_i = 1'b0;
  logic [3:0] digit1_o, digit10_o;
  logic       d1_valid_o, d10_valid_o, seg_err_o, update_o;

  int checks = 0;
  int errors = 0;
  int upd_cnt = 0;

  seg7_mux_capture #(.STABLE_CNT(4), .TIMEOUT(1024)) dut (
    .clk(clk), .rst_n(rst_n), .seg_in_i(seg_in_i), .dig_en_i(dig_en_i),
    .seg_inv_i(seg_inv_i), .dig_inv_i(dig_inv_i), .err_clr_i(err_clr_i),
    .digit1_o(digit1_o), .digit10_o(digit10_o), .d1_valid_o(d1_valid_o),
    .d10_valid_o(d10_valid_o), .seg_err_o(seg_err_o), .update_o(update_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       sinv;
    logic       dinv;
    logic [6:0] pat;
    logic [3:0] exp_d;
    logic       exp_v;
    logic       exp_err;
  } vec_t;

  vec_t vecs[16];

  task automatic tick();
    @(posedge clk);
    #1;
    if (update_o) upd_cnt++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Drives the raw lines for a logical enable and segment pattern under the given polarities.
  task automatic drive(input logic sinv, input logic dinv, input logic [1:0] en, input logic [6:0] pat);
    seg_inv_i = sinv;
    dig_inv_i = dinv;
    seg_in_i  = sinv ? ~{1'b0, pat} : {1'b0, pat};
    dig_en_i  = dinv ? ~en : en;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    upd_cnt = 0;
  endtask

  function automatic vec_t mk(input logic sinv, input logic dinv, input logic [6:0] pat,
                              input logic [3:0] d, input logic v, input logic e);
    vec_t r;
    r.sinv = sinv; r.dinv = dinv; r.pat = pat; r.exp_d = d; r.exp_v = v; r.exp_err = e;
    return r;
  endfunction

  initial begin
    vecs[0]  = mk(0, 0, 7'h3F, 4'd0, 1, 0);
    vecs[1]  = mk(1, 0, 7'h06, 4'd1, 1, 0);
    vecs[2]  = mk(0, 1, 7'h5B, 4'd2, 1, 0);
    vecs[3]  = mk(1, 1, 7'h4F, 4'd3, 1, 0);
    vecs[4]  = mk(0, 0, 7'h66, 4'd4, 1, 0);
    vecs[5]  = mk(1, 0, 7'h6D, 4'd5, 1, 0);
    vecs[6]  = mk(0, 1, 7'h7D, 4'd6, 1, 0);
    vecs[7]  = mk(1, 1, 7'h07, 4'd7, 1, 0);
    vecs[8]  = mk(0, 0, 7'h7F, 4'd8, 1, 0);
    vecs[9]  = mk(0, 0, 7'h6F, 4'd9, 1, 0);
    vecs[10] = mk(1, 0, 7'h00, 4'd0, 0, 0);
    vecs[11] = mk(0, 0, 7'h7E, 4'd0, 0, 1);
    vecs[12] = mk(1, 1, 7'h76, 4'd0, 0, 1);
`ifdef SEG7_HEX_DECODE_EN
    vecs[13] = mk(0, 0, 7'h77, 4'd10, 1, 0);
    vecs[14] = mk(1, 0, 7'h7C, 4'd11, 1, 0);
    vecs[15] = mk(0, 1, 7'h71, 4'd15, 1, 0);
`else
    vecs[13] = mk(0, 0, 7'h77, 4'd0, 0, 1);
    vecs[14] = mk(1, 0, 7'h7C, 4'd0, 0, 1);
    vecs[15] = mk(0, 1, 7'h71, 4'd0, 0, 1);
`endif

    // Reset state.
    drive(0, 0, 2'b00, 7'h00);
    rst_n = 1'b0;
    #3;
    chk("rst_digit1", digit1_o, 0);
    chk("rst_digit10", digit10_o, 0);
    chk("rst_valid", {d10_valid_o, d1_valid_o}, 0);
    chk("rst_err_upd", {seg_err_o, update_o}, 0);

    // Decode table, ones digit only; err_clr wipes the start-up conflict seen when dig_inv=1.
    for (int v = 0; v < 16; v++) begin
      drive(vecs[v].sinv, vecs[v].dinv, 2'b01, vecs[v].pat);
      do_reset();
      tick();
      tick();
      err_clr_i = 1'b1;
      tick();
      err_clr_i = 1'b0;
      for (int k = 0; k < 5; k++) tick();
      chk($sformatf("vec%0d_digit1", v), digit1_o, vecs[v].exp_d);
      chk($sformatf("vec%0d_valid1", v), d1_valid_o, vecs[v].exp_v);
      chk($sformatf("vec%0d_err", v), seg_err_o, vecs[v].exp_err);
      chk($sformatf("vec%0d_valid10", v), d10_valid_o, 0);
    end

    // Latency: commit lands on edge 6 after first presence, update for one cycle.
    drive(0, 0, 2'b01, 7'h5B);
    do_reset();
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e == 5) begin
        chk("lat_e5_valid", d1_valid_o, 0);
        chk("lat_e5_update", update_o, 0);
      end
      if (e == 6) begin
        chk("lat_e6_digit1", digit1_o, 2);
        chk("lat_e6_valid", d1_valid_o, 1);
        chk("lat_e6_update", update_o, 1);
      end
      if (e == 7) chk("lat_e7_update", update_o, 0);
    end
    chk("lat_err", seg_err_o, 0);
    chk("lat_upd_cnt", upd_cnt, 1);

    // Alternating slots, both polarities inverted.
    drive(1, 1, 2'b00, 7'h00);
    do_reset();
    for (int c = 0; c < 24; c++) begin
      if (c[0]) drive(1, 1, 2'b10, 7'h06);
      else      drive(1, 1, 2'b01, 7'h66);
      err_clr_i = (c == 3);
      tick();
    end
    err_clr_i = 1'b0;
    chk("alt_digit1", digit1_o, 4);
    chk("alt_digit10", digit10_o, 1);
    chk("alt_valid", {d10_valid_o, d1_valid_o}, 2'b11);
    chk("alt_err", seg_err_o, 0);

    // Pattern flipping every 3 samples never reaches a stable run of 4.
    drive(0, 0, 2'b01, 7'h06);
    do_reset();
    for (int c = 0; c < 36; c++) begin
      drive(0, 0, 2'b01, ((c / 3) % 2 == 0) ? 7'h06 : 7'h5B);
      tick();
    end
    chk("flip_digit1", digit1_o, 0);
    chk("flip_valid", d1_valid_o, 0);
    chk("flip_upd_cnt", upd_cnt, 0);

    // Enable conflict, clear, then clear colliding with an invalid-pattern commit.
    drive(0, 0, 2'b00, 7'h00);
    do_reset();
    tick();
    drive(0, 0, 2'b11, 7'h3F);
    tick();
    drive(0, 0, 2'b00, 7'h00);
    for (int k = 0; k < 3; k++) tick();
    chk("conf_err_set", seg_err_o, 1);
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    chk("conf_err_clr", seg_err_o, 0);
    drive(0, 0, 2'b01, 7'h7E);
    do_reset();
    for (int k = 0; k < 5; k++) tick();
    chk("coll_err_before", seg_err_o, 0);
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    chk("coll_err_setwins", seg_err_o, 1);
    chk("coll_valid", d1_valid_o, 0);

    // Display 20, then tens enable stops and the tens digit times out.
    drive(0, 0, 2'b00, 7'h00);
    do_reset();
    for (int c = 0; c < 20; c++) begin
      if (c[0]) drive(0, 0, 2'b10, 7'h5B);
      else      drive(0, 0, 2'b01, 7'h3F);
      tick();
    end
    chk("to_digit10", digit10_o, 2);
    chk("to_valid_pre", {d10_valid_o, d1_valid_o}, 2'b11);
    drive(0, 0, 2'b01, 7'h3F);
    upd_cnt = 0;
    for (int c = 0; c < 1000; c++) tick();
    chk("to_valid10_hold", d10_valid_o, 1);
    for (int c = 0; c < 100; c++) tick();
    chk("to_valid10_gone", d10_valid_o, 0);
    chk("to_digit10_zero", digit10_o, 0);
    chk("to_upd_cnt", upd_cnt, 1);
    chk("to_ones_kept", {d1_valid_o, digit1_o}, {1'b1, 4'd0});

    // Reset in the middle of a stable run.
    drive(0, 0, 2'b01, 7'h5B);
    do_reset();
    for (int k = 0; k < 8; k++) tick();
    chk("mid_first_digit1", digit1_o, 2);
    drive(0, 0, 2'b01, 7'h6D);
    for (int k = 0; k < 5; k++) tick();
    chk("mid_not_yet", digit1_o, 2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_digit1", digit1_o, 0);
    chk("mid_rst_valid", d1_valid_o, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      if (e == 5) chk("mid_e5_valid", d1_valid_o, 0);
      if (e == 6) chk("mid_e6_digit1", {d1_valid_o, digit1_o}, {1'b1, 4'd5});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
